// File: rtl/dummy_serializer.sv
// Wide-to-narrow serializer: splits each DATA_W word into DATA_W/OUT_W beats, LSB slice first.
// Define DUMMY_SERIALIZER_PARITY_EN to add the registered even-parity output out_par_o.
module dummy_serializer #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 32,
  localparam int BEATS = DATA_W / OUT_W,
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic [CNT_W-1:0]  out_idx_o
`ifdef DUMMY_SERIALIZER_PARITY_EN
  ,
  output logic              out_par_o
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]  outIdx_q, outIdx_d;
  logic              beatXfer;
  logic              wordAccept;

  // The current beat is always the low slice of the shift register, so data never depends on out_ready_i.
  assign out_valid_o = (state_q == SHIFT);
  assign out_data_o  = shiftReg_q[OUT_W-1:0];
  assign out_idx_o   = outIdx_q;
  assign out_last_o  = (outIdx_q == CNT_W'(BEATS - 1));
  assign in_ready_o  = !reset_i && ((state_q == IDLE) || (out_valid_o && out_ready_i && out_last_o));

  assign beatXfer   = out_valid_o && out_ready_i;
  assign wordAccept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      outIdx_q   <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      outIdx_q   <= outIdx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    outIdx_d   = outIdx_q;
    if (wordAccept) begin
      state_d    = SHIFT;
      shiftReg_d = in_data_i;
      outIdx_d   = '0;
    end else if (beatXfer) begin
      // The final beat is left in place so out_data_o keeps its last value while idle.
      if (out_last_o) begin
        state_d  = IDLE;
        outIdx_d = '0;
      end else begin
        shiftReg_d = shiftReg_q >> OUT_W;
        outIdx_d   = outIdx_q + CNT_W'(1);
      end
    end
  end

`ifdef DUMMY_SERIALIZER_PARITY_EN
  logic outPar_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outPar_q <= 1'b0;
    end else begin
      outPar_q <= ^shiftReg_d[OUT_W-1:0];
    end
  end

  assign out_par_o = outPar_q;
`endif

endmodule
